// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int WORD_W    = 16;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage with a synchronous write port and a registered read port.
// Both ports act only on the access strobe from the controller.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wrData,
    output logic [WORD_W-1:0] rdData
);

    logic [WORD_W-1:0] mem [MEM_WORDS];

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (access && wrEn) begin
            mem[index] <= wrData;
        end
    end

    // Read register holds its value through writes and idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdData <= '0;
        end else if (access && !wrEn) begin
            rdData <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Target side of the data-memory request interface: accepts one word access,
// stalls the requester for LATENCY cycles, then pulses done with data/error.
//
// state | meaning
// IDLE  | waiting for enable; a request is only sampled here
// BUSY  | counting down the remaining latency of a legal access
// DONE  | one-cycle completion pulse; enable is ignored
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(MEM_WORDS);
    // The acceptance edge and the commit edge are both part of the latency.
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t              state;
    state_t              stateNext;
    logic [LAT_CNT_W-1:0] cnt;
    logic                capWr;
    logic [IDX_W-1:0]    capIdx;
    logic [WORD_W-1:0]   capData;
    logic                pendErr;
    logic                reqLegal;
    logic                accept;
    logic                commit;
    logic                accWr;
    logic [IDX_W-1:0]    accIdx;
    logic [WORD_W-1:0]   accData;

    assign reqLegal = ~addr[0] && ({1'b0, addr[ADDR_W-1:1]} < WORD_LIMIT);
    assign accept   = (state == IDLE) && enable;

    // Next state plus the access strobe; a single-cycle access uses live inputs.
    always_comb begin
        stateNext = state;
        commit    = 1'b0;
        accWr     = capWr;
        accIdx    = capIdx;
        accData   = capData;
        case (state)
            IDLE: begin
                if (enable) begin
                    accWr   = wr;
                    accIdx  = addr[IDX_W:1];
                    accData = data_in;
                    if (!reqLegal) begin
                        stateNext = DONE;
                    end else if (LATENCY == 1) begin
                        commit    = 1'b1;
                        stateNext = DONE;
                    end else begin
                        stateNext = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Request capture at acceptance and latency down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            capWr   <= 1'b0;
            capIdx  <= '0;
            capData <= '0;
            pendErr <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_LOAD;
            capWr   <= wr;
            capIdx  <= addr[IDX_W:1];
            capData <= data_in;
            pendErr <= ~reqLegal;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Stall is gated by reset so it reads 0 while reset is held.
    assign stall = rst && (accept || (state == BUSY));
    assign done  = (state == DONE);
    assign err   = done && pendErr;

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) uArray (
        .clk    (clk),
        .rst    (rst),
        .access (commit),
        .wrEn   (accWr),
        .index  (accIdx),
        .wrData (accData),
        .rdData (data_out)
    );

endmodule
